// File: rtl/radio_enable_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : radio_enable_sequencer
//  Description : Per-channel radio enable qualification. Each channel waits
//                for its PLL to lock, lets the synthesizer settle for a
//                programmable number of clk cycles and only then exposes the
//                enable and RX/TX select. A loss of lock while active raises
//                a one-cycle lockLost pulse. Channels are fully independent.
//  Revision    : 1.0 - initial release
// ============================================================================
module radio_enable_sequencer #(
    parameter int BIT_WIDTH     = 2,
    parameter int SIZE_T_ARSTFS = BIT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BIT_WIDTH-1:0]     radioEnableSynced,
    input  logic [BIT_WIDTH-1:0]     radioRxEnSynced,
    input  logic [BIT_WIDTH-1:0]     pllSettled,
    input  logic [SIZE_T_ARSTFS-1:0] tArstFs,
    output logic [BIT_WIDTH-1:0]     radioEnable1,
    output logic [BIT_WIDTH-1:0]     radioRxEn1,
    output logic [BIT_WIDTH-1:0]     lockLost
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_PLL = 2'd1,
        ST_SETTLE   = 2'd2,
        ST_ACTIVE   = 2'd3
    } state_t;

    generate
        for (genvar g = 0; g < BIT_WIDTH; g++) begin : g_chan
            state_t                   r_state;
            logic [SIZE_T_ARSTFS-1:0] r_cnt;
            logic                     r_rx_latch;
            logic                     r_enable;
            logic                     r_rx_en;
            logic                     r_lock_lost;

            logic w_en;
            logic w_rx;
            logic w_pll;

            assign w_en  = radioEnableSynced[g];
            assign w_rx  = radioRxEnSynced[g];
            assign w_pll = pllSettled[g];

            // Channel FSM: priority is reset, enable drop, lock loss, RX/TX
            // change, then settle count. Outputs are registered alongside the
            // state so they never follow the inputs combinationally.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_rx_latch  <= 1'b0;
                    r_enable    <= 1'b0;
                    r_rx_en     <= 1'b0;
                    r_lock_lost <= 1'b0;
                end else begin
                    // Outputs default low; only a cycle spent in ACTIVE
                    // raises them, and lockLost only lives for one cycle.
                    r_enable    <= 1'b0;
                    r_rx_en     <= 1'b0;
                    r_lock_lost <= 1'b0;
                    if (!w_en) begin
                        r_state <= ST_IDLE;
                    end else begin
                        case (r_state)
                            ST_IDLE: begin
                                r_state    <= ST_WAIT_PLL;
                                r_rx_latch <= w_rx;
                            end
                            ST_WAIT_PLL: begin
                                if (w_pll) begin
                                    r_state    <= ST_SETTLE;
                                    r_cnt      <= tArstFs;
                                    r_rx_latch <= w_rx;
                                end
                            end
                            ST_SETTLE: begin
                                if (!w_pll) begin
                                    r_state <= ST_WAIT_PLL;
                                end else if (w_rx != r_rx_latch) begin
                                    // Direction changed mid-settle: restart
                                    // the full settle window.
                                    r_cnt      <= tArstFs;
                                    r_rx_latch <= w_rx;
                                end else if (r_cnt == '0) begin
                                    r_state  <= ST_ACTIVE;
                                    r_enable <= 1'b1;
                                    r_rx_en  <= r_rx_latch;
                                end else begin
                                    r_cnt <= r_cnt - 1'b1;
                                end
                            end
                            ST_ACTIVE: begin
                                if (!w_pll) begin
                                    r_state     <= ST_WAIT_PLL;
                                    r_lock_lost <= 1'b1;
                                end else if (w_rx != r_rx_latch) begin
                                    // Retune: synthesizer must settle again.
                                    r_state    <= ST_SETTLE;
                                    r_cnt      <= tArstFs;
                                    r_rx_latch <= w_rx;
                                end else begin
                                    r_enable <= 1'b1;
                                    r_rx_en  <= r_rx_latch;
                                end
                            end
                            default: begin
                                r_state <= ST_IDLE;
                            end
                        endcase
                    end
                end
            end

            assign radioEnable1[g] = r_enable;
            assign radioRxEn1[g]   = r_rx_en;
            assign lockLost[g]     = r_lock_lost;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/radio_enable_sequencer.md
RADIO_ENABLE_SEQUENCER -- requirements
Module: radio_enable_sequencer

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 2, giving the number of independent radio channels.
REQ-002 The block SHALL have parameter SIZE_T_ARSTFS, default BIT_WIDTH, giving the width of the settle-time input.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port radioEnableSynced, input, BIT_WIDTH bits: per-channel synchronized enable request.
REQ-006 The block SHALL have port radioRxEnSynced, input, BIT_WIDTH bits: per-channel synchronized RX (1) / TX (0) select.
REQ-007 The block SHALL have port pllSettled, input, BIT_WIDTH bits: per-channel PLL lock indication.
REQ-008 The block SHALL have port tArstFs, input, SIZE_T_ARSTFS bits: settle time in clk cycles, shared by all channels.
REQ-009 The block SHALL have port radioEnable1, output, BIT_WIDTH bits: per-channel qualified radio enable.
REQ-010 The block SHALL have port radioRxEn1, output, BIT_WIDTH bits: per-channel qualified RX enable.
REQ-011 The block SHALL have port lockLost, output, BIT_WIDTH bits: per-channel one-cycle pulse on PLL lock loss while active.

Function
REQ-012 Each channel SHALL run an independent Moore FSM with states IDLE, WAIT_PLL, SETTLE and ACTIVE, plus a SIZE_T_ARSTFS-bit down-counter cnt and a 1-bit RX latch rxL.
REQ-013 Conditions SHALL be evaluated per edge in strict priority: rst, then en=0, then pll=0, then rx≠rxL, then count.
REQ-014 IDLE: when en=1, the FSM SHALL go to WAIT_PLL and set rxL←rx.
REQ-015 WAIT_PLL: en=0 SHALL go to IDLE; else pll=1 SHALL go to SETTLE with cnt←tArstFs and rxL←rx.
REQ-016 SETTLE, en=0: the FSM SHALL go to IDLE.
REQ-017 SETTLE, pll=0: the FSM SHALL go to WAIT_PLL.
REQ-018 SETTLE, rx≠rxL: the FSM SHALL stay in SETTLE with cnt←tArstFs and rxL←rx (restart).
REQ-019 SETTLE, otherwise: cnt=0 SHALL go to ACTIVE; else cnt←cnt−1.
REQ-020 ACTIVE, en=0: the FSM SHALL go to IDLE.
REQ-021 ACTIVE, pll=0: the FSM SHALL go to WAIT_PLL and assert lockLost for exactly the next cycle.
REQ-022 ACTIVE, rx≠rxL: the FSM SHALL go to SETTLE with cnt←tArstFs and rxL←rx (retune).
REQ-023 radioEnable1[i] SHALL be 1 iff channel i is in ACTIVE; radioRxEn1[i] SHALL equal rxL when ACTIVE and 0 otherwise; both SHALL be registered/state-decoded, with no combinational path from inputs.
REQ-024 Latency: with en first sampled 1 at edge k, pll=1 and tArstFs=T held constant, radioEnable1 SHALL rise after edge k+T+2 (T=0 gives k+2).
REQ-025 tArstFs SHALL be sampled only at cnt load; later changes SHALL NOT affect a running count.
REQ-026 cnt SHALL never wrap below 0; the maximum value 2^SIZE_T_ARSTFS−1 SHALL be a valid settle time.
REQ-027 Channels SHALL share no state, and simultaneous events on different channels SHALL be handled independently in the same cycle.

Reset
REQ-028 At an edge sampling rst=1, every channel SHALL enter IDLE with cnt=0 and rxL=0.
REQ-029 From the cycle after that edge, radioEnable1, radioRxEn1 and lockLost SHALL be 0.
REQ-030 Reset mid-sequence (WAIT_PLL, SETTLE or ACTIVE) SHALL behave identically to reset from IDLE, with no lockLost pulse.
REQ-031 After rst deasserts with en already high, a channel SHALL restart from IDLE per REQ-024.

Verification
REQ-032 The bench SHALL cover basic bring-up: BIT_WIDTH=2, tArstFs=3, pll=11, en[0] rises with rx[0]=1 at edge 10 -> radioEnable1[0]=1 and radioRxEn1[0]=1 after edge 15, and channel 1 stays 0.
REQ-033 The bench SHALL cover the PLL wait: tArstFs=0, en[1]=1 at edge 5, pll[1] rises at edge 20 -> radioEnable1[1] rises after edge 21.
REQ-034 The bench SHALL cover lock loss: channel 0 ACTIVE, pll[0] drops at edge 30 -> radioEnable1[0]=0 and lockLost[0]=1 for only the cycle after edge 30; pll[0] back at edge 33 with T=3 -> active again after edge 37.
REQ-035 The bench SHALL cover retune: ACTIVE with rxL=1, rx toggles to 0 at edge 40 with T=2 -> enable low after edge 40, then enable high with radioRxEn1=0 after edge 43; a further toggle during SETTLE restarts the count.
REQ-036 The bench SHALL cover simultaneous events: at a single edge, en[0] drops while pll[0] drops in ACTIVE and rx[1] toggles -> channel 0 to IDLE with no lockLost, and channel 1 retunes.
REQ-037 The bench SHALL cover mid-operation reset: rst at edge 50 during SETTLE with en held high -> outputs 0 after edge 50; rst low at edge 51 -> enable after edge 51+T+2.
